// File: rtl/ps2_key_ascii_pkg.sv
// Shared Set-2 scan-code constants, frame geometry and the frame validity check
// used by the PS/2 keyboard front end.
package ps2_key_ascii_pkg;

    localparam logic [7:0] BREAK_CODE  = 8'hF0;
    localparam logic [7:0] EXT_CODE    = 8'hE0;
    localparam int         FRAME_BITS  = 11;
    localparam logic [7:0] ASCII_ENTER = 8'h0D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    // frame[0]=start, frame[8:1]=d0..d7, frame[9]=parity, frame[10]=stop
    function automatic logic frame_ok(input logic [FRAME_BITS-1:0] frame);
        return (frame[0] == 1'b0) && (frame[10] == 1'b1) && (^frame[9:1] == 1'b1);
    endfunction

endpackage

// File: rtl/ps2_key_ascii_frame_rx.sv
// PS/2 receive path: synchronises the keyboard lines, detects falling clock edges,
// assembles 11-bit frames and strobes byte_valid for each well-formed byte.
module ps2_frame_rx
    import ps2_key_ascii_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [2:0]            clk_sync_q, clk_sync_d;
    logic [2:0]            data_sync_q, data_sync_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-2:0] shift_q, shift_d;
    logic [TW-1:0]         idle_q, idle_d;
    logic [7:0]            byte_q, byte_d;
    logic                  valid_q, valid_d;
    logic                  fall;
    logic [FRAME_BITS-1:0] frame_next;

    always_comb begin
        clk_sync_d  = {clk_sync_q[1:0], ps2_clk};
        data_sync_d = {data_sync_q[1:0], ps2_data};
        fall        = clk_sync_q[2] & ~clk_sync_q[1];
        frame_next  = {data_sync_q[2], shift_q};
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        idle_d      = idle_q;
        byte_d      = byte_q;
        valid_d     = 1'b0;
        if (fall) begin
            idle_d  = '0;
            shift_d = frame_next[FRAME_BITS-1:1];
            if (bit_cnt_q == 4'(FRAME_BITS - 1)) begin
                bit_cnt_d = '0;
                if (frame_ok(frame_next)) begin
                    valid_d = 1'b1;
                    byte_d  = frame_next[8:1];
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            // A stalled partial frame is abandoned so we resync on the next start bit
            if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
                bit_cnt_d = '0;
                idle_d    = '0;
            end else begin
                idle_d = idle_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            idle_q      <= '0;
            byte_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            idle_q      <= idle_d;
            byte_q      <= byte_d;
            valid_q     <= valid_d;
        end
    end

    assign rx_byte    = byte_q;
    assign byte_valid = valid_q;

endmodule

// File: rtl/ps2_key_ascii.sv
// Keyboard front end for the typing game: turns the PS/2 Set-2 stream into the
// ASCII code of the currently held key plus a pulse on each new key press.
module ps2_key_ascii
    import ps2_key_ascii_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] ascii,
    output logic [7:0] scan_code,
    output logic       new_key
);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic [7:0] mapped;
    logic [7:0] ascii_q, ascii_d;
    logic [7:0] scan_q, scan_d;
    logic       new_key_q, new_key_d;
    logic       brk_q, brk_d;
    logic       ext_q, ext_d;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid)
    );

    always_comb begin
        case (rx_byte)
            8'h1C: mapped = 8'h61;
            8'h32: mapped = 8'h62;
            8'h21: mapped = 8'h63;
            8'h23: mapped = 8'h64;
            8'h24: mapped = 8'h65;
            8'h2B: mapped = 8'h66;
            8'h34: mapped = 8'h67;
            8'h33: mapped = 8'h68;
            8'h43: mapped = 8'h69;
            8'h3B: mapped = 8'h6A;
            8'h42: mapped = 8'h6B;
            8'h4B: mapped = 8'h6C;
            8'h3A: mapped = 8'h6D;
            8'h31: mapped = 8'h6E;
            8'h44: mapped = 8'h6F;
            8'h4D: mapped = 8'h70;
            8'h15: mapped = 8'h71;
            8'h2D: mapped = 8'h72;
            8'h1B: mapped = 8'h73;
            8'h2C: mapped = 8'h74;
            8'h3C: mapped = 8'h75;
            8'h2A: mapped = 8'h76;
            8'h1D: mapped = 8'h77;
            8'h22: mapped = 8'h78;
            8'h35: mapped = 8'h79;
            8'h1A: mapped = 8'h7A;
            8'h45: mapped = 8'h30;
            8'h16: mapped = 8'h31;
            8'h1E: mapped = 8'h32;
            8'h26: mapped = 8'h33;
            8'h25: mapped = 8'h34;
            8'h2E: mapped = 8'h35;
            8'h36: mapped = 8'h36;
            8'h3D: mapped = 8'h37;
            8'h3E: mapped = 8'h38;
            8'h46: mapped = 8'h39;
            8'h29: mapped = ASCII_SPACE;
            8'h5A: mapped = ASCII_ENTER;
            default: mapped = 8'h00;
        endcase
    end

    always_comb begin
        ascii_d   = ascii_q;
        scan_d    = scan_q;
        new_key_d = 1'b0;
        brk_d     = brk_q;
        ext_d     = ext_q;
        if (byte_valid) begin
            scan_d = rx_byte;
            if (rx_byte == EXT_CODE) begin
                ext_d = 1'b1;
            end else if (rx_byte == BREAK_CODE) begin
                brk_d = 1'b1;
            end else if (brk_q) begin
                // Releasing a key other than the held one leaves the held key alone
                if (mapped == ascii_q) begin
                    ascii_d = 8'h00;
                end
                brk_d = 1'b0;
                ext_d = 1'b0;
            end else if (ext_q) begin
                ext_d = 1'b0;
            end else begin
                ascii_d   = mapped;
                new_key_d = (mapped != 8'h00) && (mapped != ascii_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ascii_q   <= 8'h00;
            scan_q    <= 8'h00;
            new_key_q <= 1'b0;
            brk_q     <= 1'b0;
            ext_q     <= 1'b0;
        end else begin
            ascii_q   <= ascii_d;
            scan_q    <= scan_d;
            new_key_q <= new_key_d;
            brk_q     <= brk_d;
            ext_q     <= ext_d;
        end
    end

    assign ascii     = ascii_q;
    assign scan_code = scan_q;
    assign new_key   = new_key_q;

endmodule

// File: tb/tb_ps2_key_ascii.sv
// Scoreboard bench for ps2_key_ascii: drives PS/2 frames, predicts ascii/scan_code
// and new_key pulse counts from an independent key table, and compares after each frame.
module tb_ps2_key_ascii;

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] ascii;
    logic [7:0] scan_code;
    logic       new_key;

    ps2_key_ascii #(.TIMEOUT_CYCLES(50000)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ascii    (ascii),
        .scan_code(scan_code),
        .new_key  (new_key)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] s;
        int         p;
        int         base;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   pulse_cnt = 0;

    logic [7:0] model_ascii = 8'h00;
    logic [7:0] model_scan  = 8'h00;
    logic       model_brk   = 1'b0;
    logic       model_ext   = 1'b0;

    logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
        8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
        8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
        8'h3D, 8'h3E, 8'h46};

    always @(negedge clk) if (new_key === 1'b1) pulse_cnt++;

    function automatic logic [7:0] tb_map(input logic [7:0] b);
        for (int i = 0; i < 26; i++) if (letter_codes[i] == b) return 8'(8'h61 + i);
        for (int i = 0; i < 10; i++) if (digit_codes[i] == b) return 8'(8'h30 + i);
        if (b == 8'h29) return 8'h20;
        if (b == 8'h5A) return 8'h0D;
        return 8'h00;
    endfunction

    task automatic model_byte(input logic [7:0] b, output int p);
        logic [7:0] m;
        p = 0;
        m = tb_map(b);
        model_scan = b;
        if (b == 8'hE0) model_ext = 1'b1;
        else if (b == 8'hF0) model_brk = 1'b1;
        else if (model_brk) begin
            if (m == model_ascii) model_ascii = 8'h00;
            model_brk = 1'b0;
            model_ext = 1'b0;
        end else if (model_ext) model_ext = 1'b0;
        else begin
            if (m != 8'h00 && m != model_ascii) p = 1;
            model_ascii = m;
        end
    endtask

    // Sends the first nbits bits of a frame; bad_par inverts the parity bit.
    task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = f[i];
            repeat (5) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (10) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (5) @(negedge clk);
        end
        ps2_data = 1'b1;
    endtask

    task automatic drive_byte(input logic [7:0] b, input bit bad_par);
        int p;
        p = 0;
        if (!bad_par) model_byte(b, p);
        sb.push_back('{model_ascii, model_scan, p, pulse_cnt});
        send_bits(b, bad_par, 11);
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (ascii !== 8'h00) begin bad++; $display("FAIL reset_ascii got=%h want=00", ascii); end
        total++; if (scan_code !== 8'h00) begin bad++; $display("FAIL reset_scan got=%h want=00", scan_code); end
        total++; if (new_key !== 1'b0) begin bad++; $display("FAIL reset_new_key got=%b want=0", new_key); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_frames(input string name, input logic [7:0] bytes[$], input bit bad_par[$]);
        exp_t e;
        for (int i = 0; i < bytes.size(); i++) begin
            drive_byte(bytes[i], bad_par[i]);
            e = sb.pop_front();
            total++; if (ascii !== e.a) begin bad++; $display("FAIL %s[%0d] ascii got=%h want=%h", name, i, ascii, e.a); end
            total++; if (scan_code !== e.s) begin bad++; $display("FAIL %s[%0d] scan_code got=%h want=%h", name, i, scan_code, e.s); end
            total++; if (pulse_cnt - e.base !== e.p) begin bad++; $display("FAIL %s[%0d] new_key pulses got=%0d want=%0d", name, i, pulse_cnt - e.base, e.p); end
            $display("%s[%0d] byte=%h ascii=%h scan=%h pulses=%0d", name, i, bytes[i], ascii, scan_code, pulse_cnt - e.base);
        end
    endtask

    task automatic test_make;
        test_frames("make", '{8'h1C}, '{1'b0});
    endtask

    task automatic test_release;
        test_frames("release", '{8'h1C, 8'hF0, 8'h1C}, '{1'b0, 1'b0, 1'b0});
    endtask

    task automatic test_typematic;
        test_frames("typematic", '{8'h16, 8'h16, 8'h16, 8'h5A}, '{1'b0, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic test_bad_parity;
        test_frames("bad_parity", '{8'h1C, 8'h1C}, '{1'b1, 1'b0});
    endtask

    task automatic test_timeout;
        send_bits(8'h29, 1'b0, 5);
        repeat (50100) @(negedge clk);
        test_frames("timeout", '{8'h29}, '{1'b0});
    endtask

    task automatic test_extended;
        test_frames("extended", '{8'hF0, 8'h29, 8'hE0, 8'h75, 8'h1C}, '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic test_reset_midframe;
        send_bits(8'h5A, 1'b0, 4);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (ascii !== 8'h00) begin bad++; $display("FAIL midreset_ascii got=%h want=00", ascii); end
        total++; if (scan_code !== 8'h00) begin bad++; $display("FAIL midreset_scan got=%h want=00", scan_code); end
        total++; if (new_key !== 1'b0) begin bad++; $display("FAIL midreset_new_key got=%b want=0", new_key); end
        $display("midreset ascii=%h scan=%h new_key=%b", ascii, scan_code, new_key);
        model_ascii = 8'h00;
        model_scan  = 8'h00;
        model_brk   = 1'b0;
        model_ext   = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        test_frames("after_reset", '{8'h1C}, '{1'b0});
    endtask

    initial begin
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        rst_n    = 1'b0;
        test_reset();
        test_make();
        test_release();
        test_typematic();
        test_bad_parity();
        test_timeout();
        test_extended();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
